// File: rtl/row_sweep_scheduler.sv
// row_sweep_scheduler: walks a three-row window of horizontal roll counts one
// column per cycle and accumulates the number of accessible rolls in the grid.
// Handles the top edge (no row above), the bottom edge (final flush sweep with
// no row below) and saturates the grid total.
// Optional feature macro: ROW_SWEEP_STATS_EN adds per-row and peak-row
// accessible counts (row_accessible, max_row_accessible).
module row_sweep_scheduler #(
  parameter int unsigned MAX_COLS        = 256,
  parameter int unsigned COUNT_ROP_WIDTH = 2,
  parameter int unsigned TOTAL_WIDTH     = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                next_row,
  input  logic [MAX_COLS*COUNT_ROP_WIDTH-1:0] upper_row_rop_count,
  input  logic [MAX_COLS*COUNT_ROP_WIDTH-1:0] center_row_rop_count,
  input  logic [MAX_COLS-1:0]                 center_row_rop_mask,
  input  logic [$clog2(MAX_COLS):0]           num_cols,
  input  logic                                input_done,
  output logic                                busy,
  output logic                                row_done,
  output logic [TOTAL_WIDTH-1:0]              total_count,
  output logic                                total_valid,
  output logic                                overrun
`ifdef ROW_SWEEP_STATS_EN
  ,
  output logic [$clog2(MAX_COLS):0]           row_accessible,
  output logic [$clog2(MAX_COLS):0]           max_row_accessible
`endif
);

  localparam int unsigned COL_W = $clog2(MAX_COLS);
  localparam int unsigned NC_W  = COL_W + 1;
  localparam int unsigned CW    = COUNT_ROP_WIDTH;
  localparam int unsigned SUM_W = 4;

  typedef logic [MAX_COLS-1:0][CW-1:0] row_cnt_t;
  typedef logic [MAX_COLS-1:0]         row_mask_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t    state, state_d;
  logic [1:0] rows_seen, rows_seen_d;
  logic      pend_final, pend_final_d;
  logic      is_final, is_final_d;
  logic [COL_W-1:0] col, col_d;

  row_cnt_t  held_upper, held_upper_d;
  row_cnt_t  held_center, held_center_d;
  row_mask_t held_mask, held_mask_d;

  row_cnt_t  eval_above, eval_above_d;
  row_cnt_t  eval_mid, eval_mid_d;
  row_cnt_t  eval_below, eval_below_d;
  row_mask_t eval_mask, eval_mask_d;

  logic                   busy_d, row_done_d, total_valid_d, overrun_d;
  logic [TOTAL_WIDTH-1:0] total_count_d;

  row_cnt_t  upper_in, center_in;
  logic [NC_W-1:0]  n_eff;
  logic [NC_W-1:0]  col_inc;
  logic             last_col;
  logic [SUM_W-1:0] cell_sum;
  logic             cell_ok;
  logic [TOTAL_WIDTH-1:0] total_inc;

  // View the flat count buses as per-column fields
  assign upper_in  = upper_row_rop_count;
  assign center_in = center_row_rop_count;

  // Column datapath: clamp width, detect last column, score current cell
  assign n_eff    = (num_cols > NC_W'(MAX_COLS)) ? NC_W'(MAX_COLS) : num_cols;
  assign col_inc  = NC_W'(col) + NC_W'(1);
  assign last_col = (col_inc >= n_eff);
  assign cell_sum = SUM_W'(eval_above[col]) + SUM_W'(eval_mid[col]) + SUM_W'(eval_below[col]);
  assign cell_ok  = eval_mask[col] && (cell_sum <= SUM_W'(4));
  assign total_inc = (total_count == '1) ? total_count : total_count + TOTAL_WIDTH'(1);

  // Next-state, window snapshots and output next values
  always_comb begin
    state_d       = state;
    rows_seen_d   = rows_seen;
    pend_final_d  = pend_final;
    is_final_d    = is_final;
    col_d         = col;
    held_upper_d  = held_upper;
    held_center_d = held_center;
    held_mask_d   = held_mask;
    eval_above_d  = eval_above;
    eval_mid_d    = eval_mid;
    eval_below_d  = eval_below;
    eval_mask_d   = eval_mask;
    row_done_d    = 1'b0;
    overrun_d     = overrun;
    total_count_d = total_count;

    case (state)
      IDLE: begin
        if (next_row) begin
          if (rows_seen == 2'd0) begin
            // Top row only: nothing to evaluate until the row below arrives
            held_upper_d  = '0;
            held_center_d = center_in;
            held_mask_d   = center_row_rop_mask;
            rows_seen_d   = 2'd1;
            if (input_done) state_d = FINAL;
          end else begin
            eval_above_d  = held_upper;
            eval_mid_d    = upper_in;
            eval_mask_d   = held_mask;
            eval_below_d  = center_in;
            held_upper_d  = upper_in;
            held_center_d = center_in;
            held_mask_d   = center_row_rop_mask;
            rows_seen_d   = 2'd2;
            col_d         = '0;
            is_final_d    = 1'b0;
            if (n_eff == '0) begin
              row_done_d = 1'b1;
              state_d    = input_done ? FINAL : IDLE;
            end else begin
              state_d      = SWEEP;
              pend_final_d = input_done;
            end
          end
        end else if (input_done) begin
          state_d = FINAL;
        end
      end

      SWEEP: begin
        if (next_row) overrun_d = 1'b1;
        if (input_done && !is_final) pend_final_d = 1'b1;
        if (cell_ok) total_count_d = total_inc;
        col_d = col + COL_W'(1);
        if (last_col) begin
          row_done_d   = 1'b1;
          pend_final_d = 1'b0;
          if (is_final) state_d = DONE;
          else if (pend_final || input_done) state_d = FINAL;
          else state_d = IDLE;
        end
      end

      FINAL: begin
        if (next_row) overrun_d = 1'b1;
        pend_final_d = 1'b0;
        if (rows_seen == 2'd0) begin
          state_d = DONE;
        end else begin
          // Bottom row: nothing below it
          eval_above_d = (rows_seen >= 2'd2) ? held_upper : '0;
          eval_mid_d   = held_center;
          eval_mask_d  = held_mask;
          eval_below_d = '0;
          col_d        = '0;
          is_final_d   = 1'b1;
          if (n_eff == '0) begin
            row_done_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = SWEEP;
          end
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: state_d = IDLE;
    endcase

    busy_d        = (state_d == SWEEP) || (state_d == FINAL);
    total_valid_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rows_seen   <= 2'd0;
      pend_final  <= 1'b0;
      is_final    <= 1'b0;
      col         <= '0;
      held_upper  <= '0;
      held_center <= '0;
      held_mask   <= '0;
      eval_above  <= '0;
      eval_mid    <= '0;
      eval_below  <= '0;
      eval_mask   <= '0;
      busy        <= 1'b0;
      row_done    <= 1'b0;
      total_count <= '0;
      total_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_d;
      rows_seen   <= rows_seen_d;
      pend_final  <= pend_final_d;
      is_final    <= is_final_d;
      col         <= col_d;
      held_upper  <= held_upper_d;
      held_center <= held_center_d;
      held_mask   <= held_mask_d;
      eval_above  <= eval_above_d;
      eval_mid    <= eval_mid_d;
      eval_below  <= eval_below_d;
      eval_mask   <= eval_mask_d;
      busy        <= busy_d;
      row_done    <= row_done_d;
      total_count <= total_count_d;
      total_valid <= total_valid_d;
      overrun     <= overrun_d;
    end
  end

`ifdef ROW_SWEEP_STATS_EN
  logic [NC_W-1:0] row_acc_cnt;
  logic [NC_W-1:0] row_acc_final;

  // Count of the sweep that finishes this cycle (zero-width sweeps count 0)
  assign row_acc_final = (state == SWEEP) ? row_acc_cnt + NC_W'(cell_ok) : '0;

  // Per-sweep accessible counter, last-row snapshot and running peak
  always_ff @(posedge clk) begin
    if (rst) begin
      row_acc_cnt        <= '0;
      row_accessible     <= '0;
      max_row_accessible <= '0;
    end else if (row_done_d) begin
      row_acc_cnt    <= '0;
      row_accessible <= row_acc_final;
      if (row_acc_final > max_row_accessible) max_row_accessible <= row_acc_final;
    end else if (state == SWEEP && cell_ok) begin
      row_acc_cnt <= row_acc_cnt + NC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_row_sweep_scheduler.sv
// tb_row_sweep_scheduler: table vectors, hand-written corner sequences and
// randomized grids checked against a grid-level accessibility model.
module tb_row_sweep_scheduler;

  localparam int unsigned MAX_COLS = 256;
  localparam int unsigned CW       = 2;
  localparam int unsigned TW       = 16;
  localparam int unsigned NW       = $clog2(MAX_COLS) + 1;
  localparam int          BUDGET   = 600;

  logic clk = 1'b0;
  logic rst, next_row, input_done;
  logic [MAX_COLS*CW-1:0] upper, center;
  logic [MAX_COLS-1:0]    mask;
  logic [NW-1:0]          num_cols;
  logic busy, row_done, total_valid, overrun;
  logic [TW-1:0] total_count;

  row_sweep_scheduler dut (
    .clk                  (clk),
    .rst                  (rst),
    .next_row             (next_row),
    .upper_row_rop_count  (upper),
    .center_row_rop_count (center),
    .center_row_rop_mask  (mask),
    .num_cols             (num_cols),
    .input_done           (input_done),
    .busy                 (busy),
    .row_done             (row_done),
    .total_count          (total_count),
    .total_valid          (total_valid),
    .overrun              (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [MAX_COLS-1:0] grid [16];
  int g_n;
  int g_rows;
  int exp_total;

  typedef struct {
    int            n;
    int            nrows;
    logic [3:0][15:0] rows;
    int            exp;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int eff(input int n);
    return (n > int'(MAX_COLS)) ? int'(MAX_COLS) : n;
  endfunction

  // Horizontal count per column as the previous-row store would present it
  function automatic logic [MAX_COLS*CW-1:0] counts_of(input logic [MAX_COLS-1:0] m, input int n);
    logic [MAX_COLS*CW-1:0] v;
    int w;
    v = '0;
    w = eff(n);
    for (int c = 0; c < w; c++) begin
      int k;
      k = 0;
      for (int d = -1; d <= 1; d++)
        if (c + d >= 0 && c + d < w && m[c+d]) k++;
      v[c*CW +: CW] = CW'(k);
    end
    return v;
  endfunction

  // Reference: rolls in row r whose 3x3 window (self included) holds at most 4 rolls
  function automatic int model_row_acc(input int r);
    int w, acc;
    w = eff(g_n);
    acc = 0;
    for (int c = 0; c < w; c++) begin
      if (grid[r][c]) begin
        int k;
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (r + dr >= 0 && r + dr < g_rows && c + dc >= 0 && c + dc < w && grid[r+dr][c+dc]) k++;
        if (k <= 4) acc++;
      end
    end
    return acc;
  endfunction

  task automatic do_reset();
    rst = 1'b1; next_row = 1'b0; input_done = 1'b0;
    upper = '0; center = '0; mask = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_row(input int r);
    upper    = (r > 0) ? counts_of(grid[r-1], g_n) : '0;
    center   = counts_of(grid[r], g_n);
    mask     = grid[r];
    next_row = 1'b1;
  endtask

  // Consume the next_row edge, then wait for row_done; lat = cycles since the pulse
  task automatic wait_row_done(output int lat);
    @(posedge clk); #1 next_row = 1'b0;
    lat = 1;
    while (!row_done && lat < BUDGET) begin
      @(posedge clk); #1 lat++;
    end
  endtask

  task automatic finish_grid(output int lat, output int rds);
    input_done = 1'b1;
    @(posedge clk); #1 input_done = 1'b0;
    lat = 1;
    rds = int'(row_done);
    while (!total_valid && lat < BUDGET) begin
      @(posedge clk); #1 lat++;
      rds += int'(row_done);
    end
  endtask

  task automatic run_grid(input int n, input int nrows, output int total);
    int lat, rds;
    g_n = n; g_rows = nrows;
    num_cols = NW'(n);
    exp_total = 0;
    for (int r = 0; r < nrows; r++) begin
      drive_row(r);
      if (r == 0) begin
        @(posedge clk); #1 next_row = 1'b0;
        check("first_row_no_sweep", busy, 0);
      end else begin
        wait_row_done(lat);
        check("row_done_latency", row_done ? lat : -1, eff(n) + 1);
        exp_total += model_row_acc(r - 1);
        check("row_total", total_count, exp_total);
      end
    end
    finish_grid(lat, rds);
    check("final_valid", total_valid, 1);
    check("final_latency", lat, (nrows > 0) ? eff(n) + 2 : 2);
    check("final_row_done_count", rds, (nrows > 0) ? 1 : 0);
    if (nrows > 0) exp_total += model_row_acc(nrows - 1);
    check("final_total", total_count, exp_total);
    check("final_not_busy", busy, 0);
    total = int'(total_count);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[9];
    int tot, lat, rds;

    vecs[0] = '{n: 4, nrows: 1, rows: {16'h0, 16'h0, 16'h0, 16'h6}, exp: 2};
    vecs[1] = '{n: 3, nrows: 3, rows: {16'h0, 16'h7, 16'h7, 16'h7}, exp: 4};
    vecs[2] = '{n: 1, nrows: 1, rows: {16'h0, 16'h0, 16'h0, 16'h1}, exp: 1};
    vecs[3] = '{n: 2, nrows: 2, rows: {16'h0, 16'h0, 16'h3, 16'h3}, exp: 4};
    vecs[4] = '{n: 3, nrows: 3, rows: {16'h0, 16'h0, 16'h2, 16'h0}, exp: 1};
    vecs[5] = '{n: 4, nrows: 4, rows: {16'hF, 16'hF, 16'hF, 16'hF}, exp: 4};
    vecs[6] = '{n: 5, nrows: 1, rows: {16'h0, 16'h0, 16'h0, 16'h1F}, exp: 5};
    vecs[7] = '{n: 0, nrows: 2, rows: {16'h0, 16'h0, 16'h1, 16'h1}, exp: 0};
    vecs[8] = '{n: 4, nrows: 0, rows: {16'h0, 16'h0, 16'h0, 16'h0}, exp: 0};

    num_cols = '0;
    do_reset();
    check("reset_busy", busy, 0);
    check("reset_row_done", row_done, 0);
    check("reset_total", total_count, 0);
    check("reset_valid", total_valid, 0);
    check("reset_overrun", overrun, 0);

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      do_reset();
      for (int r = 0; r < 16; r++) grid[r] = '0;
      for (int r = 0; r < 4; r++) grid[r] = MAX_COLS'(vecs[i].rows[r]);
      run_grid(vecs[i].n, vecs[i].nrows, tot);
      check($sformatf("vec%0d_total", i), tot, vecs[i].exp);
    end

    // DONE ignores further rows
    grid[0] = MAX_COLS'(1);
    drive_row(0);
    @(posedge clk); #1 next_row = 1'b0;
    @(posedge clk); #1;
    check("done_ignores_busy", busy, 0);
    check("done_ignores_valid", total_valid, 1);
    check("done_ignores_overrun", overrun, 0);

    // input_done with no rows: valid after exactly two edges
    do_reset();
    input_done = 1'b1;
    @(posedge clk); #1 input_done = 1'b0;
    check("norows_valid_early", total_valid, 0);
    @(posedge clk); #1;
    check("norows_valid", total_valid, 1);
    check("norows_total", total_count, 0);

    // next_row while busy is dropped and flagged
    do_reset();
    g_n = 8; g_rows = 2; num_cols = NW'(8);
    grid[0] = MAX_COLS'(8'hFF); grid[1] = MAX_COLS'(8'hFF);
    drive_row(0);
    @(posedge clk); #1 next_row = 1'b0;
    drive_row(1);
    @(posedge clk); #1 next_row = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 next_row = 1'b1;
    @(posedge clk); #1 next_row = 1'b0;
    rds = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1 rds += int'(row_done);
    end
    check("overrun_set", overrun, 1);
    check("overrun_row_done_count", rds, 1);
    check("overrun_row_total", total_count, model_row_acc(0));
    finish_grid(lat, rds);
    check("overrun_final_total", total_count, model_row_acc(0) + model_row_acc(1));
    check("overrun_sticky", overrun, 1);

    // input_done two cycles into an 8-column sweep
    do_reset();
    g_n = 8; g_rows = 2; num_cols = NW'(8);
    grid[0] = MAX_COLS'(8'hB5); grid[1] = MAX_COLS'(8'h6E);
    drive_row(0);
    @(posedge clk); #1 next_row = 1'b0;
    drive_row(1);
    @(posedge clk); #1 next_row = 1'b0;
    lat = 1;
    @(posedge clk); #1 input_done = 1'b1; lat++;
    @(posedge clk); #1 input_done = 1'b0; lat++;
    while (!row_done && lat < BUDGET) begin
      @(posedge clk); #1 lat++;
    end
    check("pend_row_done_latency", lat, 9);
    check("pend_final_busy", busy, 1);
    lat = 0;
    while (!total_valid && lat < BUDGET) begin
      @(posedge clk); #1 lat++;
    end
    check("pend_final_latency", lat, 9);
    check("pend_final_total", total_count, model_row_acc(0) + model_row_acc(1));

    // Reset in the middle of a sweep
    do_reset();
    g_n = 8; g_rows = 2; num_cols = NW'(8);
    grid[0] = MAX_COLS'(8'hFF); grid[1] = MAX_COLS'(8'hFF);
    drive_row(0);
    @(posedge clk); #1 next_row = 1'b0;
    drive_row(1);
    @(posedge clk); #1 next_row = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_reset_total", total_count, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_total", total_count, 0);
    for (int r = 0; r < 16; r++) grid[r] = '0;
    grid[0] = MAX_COLS'(1);
    run_grid(1, 1, tot);
    check("after_reset_single", tot, 1);

    // Width above MAX_COLS clamps to MAX_COLS
    do_reset();
    grid[0] = '1;
    run_grid(300, 1, tot);
    check("clamp_total", tot, MAX_COLS);

    // Randomized grids against the model
    for (int it = 0; it < 14; it++) begin
      int n, nr;
      do_reset();
      n  = $urandom_range(1, 20);
      nr = $urandom_range(1, 6);
      for (int r = 0; r < 16; r++) begin
        grid[r] = '0;
        for (int w = 0; w < 8; w++)
          grid[r][w*32 +: 32] = (it % 2 == 0) ? ($urandom() & $urandom()) : $urandom();
      end
      run_grid(n, nr, tot);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
